select_scan_mux: RTL and testbench
==================================

// Module: select_scan_mux
// PURPOSE
//  Parametrised, registered N-to-1 selector for packed multi-bit data lines; next generation of the
//  16-to-1 x 2-bit selector. Two modes: DIRECT (registered select, 1-cycle latency) and SCAN
//  (snapshot all lines, stream them out in order over a valid/ready handshake, pulse done).
//  Sits between board/cell-state storage and serial consumers (display/render, rule checkers).
// PARAMETERS
//  NUM_CH   16  number of input lines, >=2, power of two not required
//  DATA_W    2  width of each line in bits, >=1
//  SEL_W    localparam = $clog2(NUM_CH), width of select/index
// PORTS
//  clk        in   1               single clock, all logic rising-edge
//  reset      in   1               synchronous, active-high
//  in_bus     in   NUM_CH*DATA_W   line i = in_bus[i*DATA_W +: DATA_W]
//  mode       in   1               0 = DIRECT, 1 = SCAN; sampled only in IDLE
//  select     in   SEL_W           DIRECT-mode line index
//  start      in   1               SCAN-mode start request, one-cycle level sample
//  out_data   out  DATA_W          selected/streamed line (registered)
//  out_index  out  SEL_W           index of line on out_data (registered)
//  out_valid  out  1               out_data/out_index qualify
//  out_ready  in   1               consumer accept; used in SCAN only
//  busy       out  1               1 in SCAN and DONE
//  done       out  1               1-cycle pulse after last line accepted
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; out_data, out_index, out_valid, busy, done, shadow,
//   index counter all 0. Reset wins over every other input in the same cycle, including mid-scan.
//  States: IDLE, SCAN, DONE. All outputs registered; no combinational input->output path.
//  IDLE, mode=0 (DIRECT): each cycle out_data<=line[select], out_index<=select,
//   out_valid<=(select<NUM_CH). Out-of-range select (non-power-of-two NUM_CH): out_data<=0,
//   out_valid<=0. Latency 1 cycle. out_ready ignored.
//  IDLE, mode=1, start=0: out_valid<=0, out_data/out_index hold.
//  IDLE, mode=1, start=1 (cycle t): shadow<=in_bus, idx<=0, -> SCAN. Cycle t+1: out_valid=1,
//   out_index=0, out_data=in_bus@t line 0. in_bus changes after t do not affect the scan.
//  SCAN: line idx presented with out_valid=1. Handshake = out_valid & out_ready at rising edge.
//   No handshake: out_data/out_index held stable. Handshake with idx<NUM_CH-1: idx+1 presented
//   next cycle (back-to-back streaming, 1 line/cycle when out_ready held high).
//   Handshake with idx==NUM_CH-1: -> DONE, out_valid<=0, done<=1.
//  DONE: exactly one cycle; done=1, busy=1, out_valid=0; -> IDLE. done=0 in all other states.
//  start while busy (SCAN/DONE) ignored; no queuing. mode/select changes during SCAN/DONE ignored.
//  idx never wraps: terminates at NUM_CH-1. First DIRECT output available cycle after DONE.
//  Width rules: line slices zero-extended nowhere; out_index exactly SEL_W bits.
// STRUCTURE
//  Package select_pkg: state enum {IDLE, SCAN, DONE} (2-bit encoding), MODE_DIRECT=1'b0,
//   MODE_SCAN=1'b1.
//  One sub-module: select_n_to_1 (parametrised NUM_CH/DATA_W combinational slice mux with
//   in-range flag), instanced once, fed by in_bus (DIRECT) or shadow (SCAN) via a 2:1 source mux.
//  Top holds FSM, idx counter, shadow register, output registers.
// TESTING
//  1 Reset mid-scan: start, accept 3 lines, reset=1 one cycle -> next cycle all outputs 0, IDLE,
//    further out_ready pulses produce no data.
//  2 DIRECT, NUM_CH=16, DATA_W=2, in_bus=32'hE4E4_E4E4, select=5 -> next cycle out_data=2'b01,
//    out_index=5, out_valid=1; sweep select 0..15, each checked 1 cycle later.
//  3 SCAN with out_ready=1 constant, same in_bus: start@t -> lines 0..15 on t+1..t+16, values
//    00,01,10,11 repeating; done=1 at t+17 only; busy 1 from t+1 to t+17.
//  4 Backpressure: out_ready random 30% -> every line exactly once, in order, data held while
//    valid&!ready; in_bus rewritten to 0 after start -> streamed values still the snapshot.
//  5 start asserted during SCAN and in DONE -> ignored, single done pulse; start in the cycle
//    after DONE (IDLE) -> new scan begins.
//  6 NUM_CH=5, DATA_W=3 build: DIRECT select=6 -> out_valid=0, out_data=0; SCAN emits 5 lines,
//    out_index 0..4, done after index 4.

Source files
------------

// File: rtl/select_pkg.sv
// select_pkg: shared state encoding and mode constants for the select/scan multiplexer.
package select_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/select_n_to_1.sv
// select_n_to_1: combinational N-to-1 slice mux with an in-range flag.
//   lines_i    packed lines, line g = lines_i[g*DATA_W +: DATA_W]
//   sel_i      line index
//   data_o     selected line, zero when sel_i is out of range
//   in_range_o sel_i < NUM_CH
module select_n_to_1 #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 2,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH*DATA_W-1:0] lines_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     in_range_o
);
    logic [DATA_W-1:0] line [NUM_CH];
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign line[g] = lines_i[g*DATA_W +: DATA_W];
    end
    // Compare one bit wider so NUM_CH itself is representable.
    assign in_range_o = {1'b0, sel_i} < (SEL_W+1)'(NUM_CH);
    assign data_o     = in_range_o ? line[sel_i] : '0;
endmodule

// File: rtl/select_scan_mux.sv
// select_scan_mux: registered N-to-1 line selector with DIRECT and SCAN (snapshot + stream) modes.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_bus              packed input lines
//   mode, select, start DIRECT/SCAN choice, DIRECT index, SCAN start (all sampled in IDLE)
//   out_data/out_index  registered line and its index, qualified by out_valid
//   out_ready           consumer accept during SCAN
//   busy, done          busy in SCAN/DONE, done pulses one cycle after the last line
module select_scan_mux
    import select_pkg::*;
#(
    parameter int   NUM_CH = 16,
    parameter int   DATA_W = 2,
    localparam int  SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_bus,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    input  logic                     start,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
    state_e                    state_q;
    logic [SEL_W-1:0]          idx_q, idx_d, out_index_q, sel_d;
    logic [NUM_CH*DATA_W-1:0]  shadow_q, src_d;
    logic [DATA_W-1:0]         out_data_q, mux_data;
    logic                      out_valid_q, busy_q, done_q, mux_ok;
    // The mux always computes the value to be registered next: in SCAN that is the
    // following snapshot line; in IDLE it is line[select], or line 0 when a scan starts.
    always_comb begin
        idx_d = idx_q + SEL_W'(1);
        src_d = (state_q == SCAN) ? shadow_q : in_bus;
        sel_d = (state_q == SCAN) ? idx_d : ((mode == MODE_SCAN) ? '0 : select);
    end
    select_n_to_1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux (
        .lines_i    (src_d),
        .sel_i      (sel_d),
        .data_o     (mux_data),
        .in_range_o (mux_ok)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (mode == MODE_DIRECT) begin
                        out_data_q  <= mux_data;
                        out_index_q <= select;
                        out_valid_q <= mux_ok;
                    end else if (start) begin
                        shadow_q    <= in_bus;
                        idx_q       <= '0;
                        out_data_q  <= mux_data;
                        out_index_q <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (out_valid_q && out_ready) begin
                        if (idx_q == LAST) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            idx_q       <= idx_d;
                            out_index_q <= idx_d;
                            out_data_q  <= mux_data;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_select_scan_mux.sv
// tb_select_scan_mux: directed self-checking bench for select_scan_mux (16x2 and 5x3 builds).
module tb_select_scan_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_bus;
    logic        mode, start, ready;
    logic [3:0]  sel;
    logic [1:0]  out_data;
    logic [3:0]  out_index;
    logic        out_valid, busy, done;
    logic [14:0] in5;
    logic        mode5, start5, ready5;
    logic [2:0]  sel5;
    logic [2:0]  out_data5;
    logic [2:0]  out_index5;
    logic        out_valid5, busy5, done5;
    int          n_cmp = 0;
    int          n_err = 0;
    always #5 clk = ~clk;
    select_scan_mux #(.NUM_CH(16), .DATA_W(2)) dut (
        .clk(clk), .reset(reset), .in_bus(in_bus), .mode(mode), .select(sel), .start(start),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(ready),
        .busy(busy), .done(done)
    );
    select_scan_mux #(.NUM_CH(5), .DATA_W(3)) dut5 (
        .clk(clk), .reset(reset), .in_bus(in5), .mode(mode5), .select(sel5), .start(start5),
        .out_data(out_data5), .out_index(out_index5), .out_valid(out_valid5), .out_ready(ready5),
        .busy(busy5), .done(done5)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        logic [2:0] exp5 [5];
        int         nxt, ndone;
        exp5 = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
        reset = 1'b1; in_bus = '0; mode = 1'b0; sel = '0; start = 1'b0; ready = 1'b0;
        in5 = '0; mode5 = 1'b0; sel5 = '0; start5 = 1'b0; ready5 = 1'b0;
        step(); step();
        chk("rst_data", 32'(out_data), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst5_valid", 32'(out_valid5), 0);
        reset = 1'b0;
        // DIRECT: 0xE4 packs lines 00,01,10,11
        in_bus = 32'hE4E4_E4E4; sel = 4'd5;
        step();
        chk("dir5_data", 32'(out_data), 1);
        chk("dir5_index", 32'(out_index), 5);
        chk("dir5_valid", 32'(out_valid), 1);
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            step();
            chk("dir_sweep_data", 32'(out_data), 32'(i % 4));
            chk("dir_sweep_index", 32'(out_index), 32'(i));
            chk("dir_sweep_valid", 32'(out_valid), 1);
        end
        // SCAN with ready held high
        mode = 1'b1; start = 1'b1; ready = 1'b1; sel = 4'd9;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("scan_valid", 32'(out_valid), 1);
            chk("scan_index", 32'(out_index), 32'(i));
            chk("scan_data", 32'(out_data), 32'(i % 4));
            chk("scan_busy", 32'(busy), 1);
            chk("scan_done", 32'(done), 0);
            step();
        end
        chk("scan_end_done", 32'(done), 1);
        chk("scan_end_busy", 32'(busy), 1);
        chk("scan_end_valid", 32'(out_valid), 0);
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_hold_index", 32'(out_index), 15);
        chk("idle_valid", 32'(out_valid), 0);
        // Backpressure: 0x1B packs lines 11,10,01,00; bus cleared after the snapshot
        in_bus = 32'h1B1B_1B1B; start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0; in_bus = '0; nxt = 0;
        for (int c = 0; c < 400 && nxt < 16; c++) begin
            ready = ($urandom_range(0, 9) < 3);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_index", 32'(out_index), 32'(nxt));
            chk("bp_data", 32'(out_data), 32'(3 - nxt % 4));
            step();
            if (ready) nxt++;
        end
        chk("bp_all_lines", 32'(nxt), 16);
        chk("bp_done", 32'(done), 1);
        ready = 1'b0;
        step();
        // start held through SCAN and DONE: one done pulse, then restart from IDLE
        in_bus = 32'hE4E4_E4E4; start = 1'b1; ready = 1'b1; ndone = 0;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            if (done) ndone++;
        end
        chk("st_done_pulse", 32'(done), 1);
        step();
        if (done) ndone++;
        chk("st_idle_busy", 32'(busy), 0);
        chk("st_idle_done", 32'(done), 0);
        step();
        chk("st_done_count", 32'(ndone), 1);
        chk("st_restart_valid", 32'(out_valid), 1);
        chk("st_restart_index", 32'(out_index), 0);
        chk("st_restart_busy", 32'(busy), 1);
        start = 1'b0;
        // Reset mid-scan after three accepted lines
        step(); step(); step();
        chk("mid_index", 32'(out_index), 3);
        reset = 1'b1;
        step();
        reset = 1'b0; ready = 1'b0;
        chk("mr_data", 32'(out_data), 0);
        chk("mr_index", 32'(out_index), 0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            ready = 1'b1;
            step();
            ready = 1'b0;
            chk("mr_quiet_valid", 32'(out_valid), 0);
            chk("mr_quiet_index", 32'(out_index), 0);
            chk("mr_quiet_busy", 32'(busy), 0);
        end
        // 5-line, 3-bit build
        in5 = {3'd7, 3'd6, 3'd5, 3'd2, 3'd1}; mode5 = 1'b0; sel5 = 3'd6;
        step();
        chk("n5_oor_valid", 32'(out_valid5), 0);
        chk("n5_oor_data", 32'(out_data5), 0);
        sel5 = 3'd2;
        step();
        chk("n5_dir2_data", 32'(out_data5), 5);
        chk("n5_dir2_valid", 32'(out_valid5), 1);
        sel5 = 3'd4;
        step();
        chk("n5_dir4_data", 32'(out_data5), 7);
        mode5 = 1'b1; start5 = 1'b1; ready5 = 1'b1;
        step();
        start5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("n5_scan_valid", 32'(out_valid5), 1);
            chk("n5_scan_index", 32'(out_index5), 32'(i));
            chk("n5_scan_data", 32'(out_data5), 32'(exp5[i]));
            step();
        end
        chk("n5_done", 32'(done5), 1);
        chk("n5_end_valid", 32'(out_valid5), 0);
        step();
        chk("n5_idle_done", 32'(done5), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
